uart_tx_buffered: RTL and testbench
===================================

// Module: uart_tx_buffered
// PURPOSE
//  Buffered RS232 transmitter: a byte FIFO in front of an 8N1 serialiser with its own baud generator.
//  Lets a producer (display/command logic) queue several bytes in back-to-back cycles, then drains them
//  onto rs232_tx. It is the send-side counterpart to the existing receive path and shares its baud plan.
// PARAMETERS
//  CLK_FREQ    50000000  system clock frequency, Hz
//  BAUD        9600      line rate; BPS_CNT = CLK_FREQ/BAUD clocks per bit (5208 at defaults)
//  FIFO_DEPTH  16        FIFO entries; power of 2, 2..256
// PORTS
//  clk        in   1              system clock, all logic on rising edge
//  rst        in   1              synchronous reset, active high
//  wr_data    in   8              byte to queue
//  wr_en      in   1              queue wr_data this cycle (single-cycle strobe per byte)
//  full       out  1              FIFO full; wr_en ignored while high
//  empty      out  1              FIFO empty
//  level      out  $clog2(D)+1    FIFO occupancy, 0..FIFO_DEPTH
//  overflow   out  1              1-cycle pulse when wr_en is seen while full (byte dropped)
//  busy       out  1              frame in progress (state != IDLE)
//  rs232_tx   out  1              serial line, idle high
// BEHAVIOUR
//  - Reset: rs232_tx=1, busy=0, full=0, empty=1, level=0, overflow=0; FIFO pointers cleared; state IDLE.
//  - Reset mid-frame aborts the frame: line is high from the cycle after rst; queued bytes are discarded.
//  - FIFO write: accepted when wr_en && !full (registered full). Write while full drops the byte and pulses overflow.
//  - FIFO pop: only in IDLE when !empty; the byte is latched into the shift register in the same cycle.
//  - Simultaneous write+pop: both take effect; level unchanged. Write while full is refused even if a pop
//    happens in the same cycle.
//  - Pointers are $clog2(D) bits wide and wrap modulo FIFO_DEPTH; full/empty are derived from level.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//    START drives 0. DATA drives bits LSB first, 8 bits. STOP drives 1.
//    Each state lasts exactly BPS_CNT clocks, timed by a bit counter that is cleared on every state/bit change.
//  - STOP->IDLE takes one cycle; if the FIFO is non-empty, the next START follows immediately
//    (inter-frame gap = 1 clk beyond stop bit).
//  - Latency: wr_en at cycle 0 into an empty idle block -> empty=0 at cycle 1 -> pop and rs232_tx=0 at cycle 2.
//  - rs232_tx is driven from a flop (glitch-free). busy is high from the first START cycle to the last STOP cycle.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state after DATA, drives even parity (^byte), frame = 11 bits.
//  Not defined: no PARITY state, 8N1, frame = 10 bits. No other logic differs.
// STRUCTURE
//  - uart_pkg holds: FSM state localparams (IDLE/START/DATA/PARITY/STOP), the BPS_CNT computation
//    function, and the bit-counter width.
//  - Sub-module uart_tx_fifo: synchronous FIFO (wr/rd/full/empty/level). Top holds the baud counter,
//    FSM and shift register.
// TESTING (bench at CLK_FREQ=50000000, BAUD=9600, check bit centres at 2604+5208*k clks)
//  - Single byte 8'h55 -> line sequence 0,1,0,1,0,1,0,1,0,1 (start..stop); busy high 52080 clks; empty=1 after.
//  - Burst 8'hA5,8'h3C,8'hFF in 3 consecutive cycles -> level reaches 2 (one already popped), three frames
//    back-to-back, 1-clk gap, bytes decoded in order.
//  - 17 writes while line busy, FIFO_DEPTH=16 -> full=1 after 16th accepted, overflow pulses once, 17th byte
//    never appears on line.
//  - rst asserted mid-DATA of 8'h81 with 4 queued -> rs232_tx=1 next cycle, level=0, no further frames.
//  - Write on the same cycle a pop occurs with level=1 -> level stays 1, both bytes transmitted.
//  - With UART_TX_PARITY_EN: 8'h07 -> parity bit 1, then stop; 8'h03 -> parity bit 0; frame is 57288 clks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, baud divisor helper and bit-counter width.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Wide enough for 5208 clocks/bit at the default 50 MHz / 9600 baud plan.
    localparam int unsigned BIT_CNT_W = 16;
    localparam int unsigned DATA_BITS = 8;

    function automatic int unsigned calc_bps_cnt(input int unsigned clk_freq, input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with registered full/empty/level and a one-cycle overflow pulse.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               wr_data,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_ok_c;
    logic             rd_ok_c;
    logic [LVL_W-1:0] level_nxt_c;

    // A write is refused whenever full was registered, even if a pop happens alongside.
    assign wr_ok_c     = wr_en && !full;
    assign rd_ok_c     = rd_en && !empty;
    assign level_nxt_c = level + LVL_W'(wr_ok_c) - LVL_W'(rd_ok_c);
    assign rd_data     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr_ok_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_ok_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level    <= level_nxt_c;
            full     <= (level_nxt_c == LVL_W'(DEPTH));
            empty    <= (level_nxt_c == '0);
            overflow <= wr_en && full;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 RS232 transmitter: byte FIFO feeding a baud-timed serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_en,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          busy,
    output logic                          rs232_tx
);

    localparam int unsigned BPS_CNT = calc_bps_cnt(CLK_FREQ, BAUD);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(BPS_CNT - 1);

    tx_state_e            state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [2:0]           bit_idx;
    logic [7:0]           shreg;
    logic [7:0]           rd_data;
    logic                 rd_en_c;
    logic                 bit_done_c;

    // Pop only from IDLE; the popped byte is captured into shreg on the same edge.
    assign rd_en_c    = (state == ST_IDLE) && !empty;
    assign bit_done_c = (bit_cnt == BIT_LAST);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd_en    (rd_en_c),
        .rd_data  (rd_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    // Frame sequencer; rs232_tx is always the flop output so the line never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            busy     <= 1'b0;
            rs232_tx <= 1'b1;
        end else begin
            bit_cnt <= bit_done_c ? '0 : bit_cnt + BIT_CNT_W'(1);
            unique case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    if (!empty) begin
                        shreg    <= rd_data;
                        state    <= ST_START;
                        busy     <= 1'b1;
                        rs232_tx <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_done_c) begin
                        state    <= ST_DATA;
                        bit_idx  <= '0;
                        rs232_tx <= shreg[0];
                    end
                end
                ST_DATA: begin
                    if (bit_done_c) begin
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state    <= ST_PARITY;
                            rs232_tx <= ^shreg;
`else
                            state    <= ST_STOP;
                            rs232_tx <= 1'b1;
`endif
                        end else begin
                            bit_idx  <= bit_idx + 3'd1;
                            rs232_tx <= shreg[bit_idx + 3'd1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_done_c) begin
                        state    <= ST_STOP;
                        rs232_tx <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_done_c) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    rs232_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Randomised self-checking bench for uart_tx_buffered against a frame-timeline reference model.
module tb_uart_tx_buffered;

    localparam int unsigned CLK_FREQ = 160;
    localparam int unsigned BAUD     = 10;
    localparam int unsigned DEPTH    = 16;
    localparam int          BPS      = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int          NBITS    = 11;
`else
    localparam int          NBITS    = 10;
`endif
    localparam int          FRAME    = NBITS * BPS;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic       busy;
    logic       rs232_tx;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending bytes, current frame start interval and byte, interval counter.
    logic [7:0] mq[$];
    int         t      = 0;
    bit         active = 1'b0;
    int         s      = 0;
    logic [7:0] fbyte  = 8'h00;
    bit         m_ovf  = 1'b0;

    uart_tx_buffered #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .busy     (busy),
        .rs232_tx (rs232_tx)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @t=%0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    // Line level for bit slot k of a frame carrying byte b.
    function automatic logic exp_line(input int k, input logic [7:0] b);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Advance the model across one rising edge using the pre-edge state.
    task automatic model_edge(input bit r, input bit we, input logic [7:0] d);
        bit full_pre;
        bit idle;
        if (r) begin
            mq.delete();
            active = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            full_pre = (mq.size() == DEPTH);
            idle     = !active || (t >= s + FRAME);
            m_ovf    = we && full_pre;
            if (idle && mq.size() > 0) begin
                fbyte  = mq.pop_front();
                s      = t + 1;
                active = 1'b1;
            end
            if (we && !full_pre) mq.push_back(d);
        end
        t++;
    endtask

    task automatic check_outputs();
        bit         on;
        logic       e_tx;
        logic [7:0] e_fifo;
        on     = active && (t < s + FRAME);
        e_tx   = on ? exp_line((t - s) / BPS, fbyte) : 1'b1;
        e_fifo = {(mq.size() == DEPTH), (mq.size() == 0), m_ovf, 5'(mq.size())};
        check_eq("line{tx,busy}", 32'({rs232_tx, busy}), 32'({e_tx, on}));
        check_eq("fifo{full,empty,ovf,level}", 32'({full, empty, overflow, level}), 32'(e_fifo));
    endtask

    task automatic step(input bit r, input bit we, input logic [7:0] d);
        rst     = r;
        wr_en   = we;
        wr_data = d;
        @(posedge clk);
        model_edge(r, we, d);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;

        repeat (3) step(1'b1, 1'b0, 8'h00);

        // Single byte
        step(1'b0, 1'b1, 8'h55);
        idle(FRAME + 4);
        check_eq("empty_after_55", 32'(empty), 32'd1);

        // Back-to-back burst
        step(1'b0, 1'b1, 8'hA5);
        step(1'b0, 1'b1, 8'h3C);
        step(1'b0, 1'b1, 8'hFF);
        idle(3 * FRAME + 8);

        // Overfill while the line is busy: 16 accepted, 17th dropped
        step(1'b0, 1'b1, 8'($urandom));
        idle(3);
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'(i * 13 + 1));
        idle(17 * FRAME + 20);

        // Reset in the middle of a data phase with bytes queued
        step(1'b0, 1'b1, 8'h81);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'hC0 + i));
        idle(BPS * 3);
        step(1'b1, 1'b0, 8'h00);
        idle(2 * FRAME);

        // Write coinciding with a pop at level 1
        step(1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b1, 8'h22);
        idle(2 * FRAME + 5);

        // Random traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 1999) == 0), ($urandom_range(0, 29) == 0), 8'($urandom));
        end
        idle(DEPTH * FRAME + 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
